// File: rtl/uart_retrans_param.sv
// Parametrised UART frame receiver with timed resend requests and a sticky fail.
// Optional break detection is enabled by defining UART_RETRANS_BREAK_DET_EN.
module uart_retrans_param #(
    parameter int unsigned DATA_BITS      = 7,
    parameter int unsigned PARITY_ODD     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 error,
    output logic                 request_resend,
    output logic [CNT_W-1:0]     resend_count,
    output logic                 fail,
    output logic                 break_det
);

    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
    localparam int unsigned TM_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_PAR, S_STOP, S_VALID, S_ERR, S_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 par_q, par_d;
    logic [TM_W-1:0]      timer_q, timer_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 req_q, req_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fail_q, fail_d;
    logic                 brk_q, brk_d;
    logic                 parity_ok;

    assign parity_ok = ((^rx_q) ^ par_q) == 1'(PARITY_ODD);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            par_q     <= 1'b0;
            timer_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            req_q     <= 1'b0;
            cnt_q     <= '0;
            fail_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            par_q     <= par_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            brk_q     <= brk_d;
        end
    end

    // Next-state and output decisions
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        par_d     = par_q;
        timer_d   = timer_q;
        data_d    = data_q;
        valid_d   = valid_q;
        error_d   = error_q;
        req_d     = 1'b0;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        brk_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!signal) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                // LSB arrives first, so shift in from the top
                rx_d      = (rx_q >> 1) | (DATA_BITS'(signal) << (DATA_BITS - 1));
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                    state_d = S_PAR;
                end
            end
            S_PAR: begin
                par_d   = signal;
                state_d = S_STOP;
            end
            S_STOP: begin
`ifdef UART_RETRANS_BREAK_DET_EN
                if (rx_q == '0 && !par_q && !signal) begin
                    brk_d   = 1'b1;
                    state_d = S_IDLE;
                end else
`endif
                if (parity_ok && signal) begin
                    state_d = S_VALID;
                    valid_d = 1'b1;
                    data_d  = rx_q;
                end else begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    timer_d = '0;
                end
            end
            S_VALID: begin
                if (ack) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (timer_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b0;
                    if (cnt_q < CNT_W'(MAX_RETRIES)) begin
                        req_d   = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        fail_d  = 1'b1;
                        data_d  = '0;
                        state_d = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data           = data_q;
    assign valid          = valid_q;
    assign error          = error_q;
    assign request_resend = req_q;
    assign resend_count   = cnt_q;
    assign fail           = fail_q;
`ifdef UART_RETRANS_BREAK_DET_EN
    assign break_det      = brk_q;
`else
    assign break_det      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_retrans_param.sv
// Directed bench for uart_retrans_param: default instance plus an 8-bit odd-parity instance.
module tb_uart_retrans_param;

    logic clk = 1'b0;
    logic reset;
    logic sig0, ack0, sig1, ack1;

    logic [6:0] data0;
    logic       valid0, error0, req0, fail0, brk0;
    logic [4:0] cnt0;
    logic [7:0] data1;
    logic       valid1, error1, req1, fail1, brk1;
    logic [4:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_retrans_param u0 (
        .clk(clk), .reset(reset), .signal(sig0), .ack(ack0),
        .data(data0), .valid(valid0), .error(error0), .request_resend(req0),
        .resend_count(cnt0), .fail(fail0), .break_det(brk0)
    );

    uart_retrans_param #(.DATA_BITS(8), .PARITY_ODD(1)) u1 (
        .clk(clk), .reset(reset), .signal(sig1), .ack(ack1),
        .data(data1), .valid(valid1), .error(error1), .request_resend(req1),
        .resend_count(cnt1), .fail(fail1), .break_det(brk1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive start, nbits data LSB first, parity, stop onto instance 0 or 1
    task automatic send(input int which, input int nbits, input logic [15:0] d,
                        input logic p, input logic s);
        logic [15:0] w;
        w = d;
        if (which == 0) sig0 = 1'b0; else sig1 = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) sig0 = w[i]; else sig1 = w[i];
            tick();
        end
        if (which == 0) sig0 = p; else sig1 = p;
        tick();
        if (which == 0) sig0 = s; else sig1 = s;
        tick();
        sig0 = 1'b1;
        sig1 = 1'b1;
    endtask

    // Bad-parity frame on instance 0 followed by its timeout and resend pulse
    task automatic bad_retry(input logic [4:0] exp_cnt);
        send(0, 7, 16'h0D, 1'b0, 1'b1);
        chk("bad_error_set", 32'(error0), 32'd1);
        repeat (7) tick();
        chk("bad_no_early_req", 32'(req0), 32'd0);
        tick();
        chk("bad_req_pulse", 32'(req0), 32'd1);
        chk("bad_cnt", 32'(cnt0), 32'(exp_cnt));
        chk("bad_error_clr", 32'(error0), 32'd0);
        tick();
        chk("bad_req_one_cycle", 32'(req0), 32'd0);
    endtask

    task automatic async_reset_low;
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic release_reset;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic saw_req;
        reset = 1'b0;
        sig0 = 1'b1; sig1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
        #3;
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_error", 32'(error0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_fail", 32'(fail0), 32'd0);
        chk("rst_brk", 32'(brk0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        tick();
        release_reset();
        tick();

        // Good frame 0x0D, even parity 1
        send(0, 7, 16'h0D, 1'b1, 1'b1);
        chk("good_valid", 32'(valid0), 32'd1);
        chk("good_data", 32'(data0), 32'h0D);
        chk("good_error", 32'(error0), 32'd0);
        tick();
        chk("good_held", 32'(valid0), 32'd1);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("ack_valid", 32'(valid0), 32'd0);
        chk("ack_cnt", 32'(cnt0), 32'd0);
        chk("ack_data_kept", 32'(data0), 32'h0D);

        // Bad frames, then a good frame and ack clears the count
        bad_retry(5'd1);
        bad_retry(5'd2);
        send(0, 7, 16'h0D, 1'b1, 1'b1);
        chk("t4_valid", 32'(valid0), 32'd1);
        chk("t4_cnt_held", 32'(cnt0), 32'd2);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("t4_cnt_cleared", 32'(cnt0), 32'd0);

        // Retry budget exhaustion
        bad_retry(5'd1);
        bad_retry(5'd2);
        bad_retry(5'd3);
        send(0, 7, 16'h0D, 1'b0, 1'b1);
        chk("t3_err4", 32'(error0), 32'd1);
        repeat (8) tick();
        chk("t3_fail", 32'(fail0), 32'd1);
        chk("t3_no_req", 32'(req0), 32'd0);
        chk("t3_error_clr", 32'(error0), 32'd0);
        chk("t3_cnt_max", 32'(cnt0), 32'd3);
        tick();
        send(0, 7, 16'h0D, 1'b1, 1'b1);
        tick();
        chk("t3_fail_sticky", 32'(fail0), 32'd1);
        chk("t3_valid_blocked", 32'(valid0), 32'd0);
        chk("t3_data_zero", 32'(data0), 32'd0);
        async_reset_low();
        chk("t3_rst_fail", 32'(fail0), 32'd0);
        chk("t3_rst_cnt", 32'(cnt0), 32'd0);
        release_reset();
        tick();

        // All-zero frame
        send(0, 7, 16'h00, 1'b0, 1'b0);
`ifdef UART_RETRANS_BREAK_DET_EN
        chk("brk_pulse", 32'(brk0), 32'd1);
        chk("brk_no_error", 32'(error0), 32'd0);
        tick();
        chk("brk_one_cycle", 32'(brk0), 32'd0);
        repeat (8) tick();
        chk("brk_no_req", 32'(req0), 32'd0);
        chk("brk_cnt", 32'(cnt0), 32'd0);
`else
        chk("brk_tied0", 32'(brk0), 32'd0);
        chk("brk_as_error", 32'(error0), 32'd1);
        repeat (8) tick();
        chk("brk_req", 32'(req0), 32'd1);
        chk("brk_cnt", 32'(cnt0), 32'd1);
        tick();
`endif

        // Async reset mid-DATA with nonzero data and count
        send(0, 7, 16'h0D, 1'b1, 1'b1);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        bad_retry(5'd1);
        sig0 = 1'b0;
        tick();
        sig0 = 1'b1;
        tick();
        tick();
        async_reset_low();
        chk("mid_data_rst_data", 32'(data0), 32'd0);
        chk("mid_data_rst_cnt", 32'(cnt0), 32'd0);
        chk("mid_data_rst_valid", 32'(valid0), 32'd0);
        release_reset();
        tick();

        // Async reset mid-ERR
        send(0, 7, 16'h0D, 1'b0, 1'b1);
        chk("mid_err_set", 32'(error0), 32'd1);
        repeat (3) tick();
        async_reset_low();
        chk("mid_err_rst_error", 32'(error0), 32'd0);
        chk("mid_err_rst_req", 32'(req0), 32'd0);
        release_reset();
        saw_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req0 || error0) saw_req = 1'b1;
        end
        chk("mid_err_no_pulse", 32'(saw_req), 32'd0);

        // 8-bit odd-parity instance
        send(1, 8, 16'hA5, 1'b1, 1'b1);
        chk("odd_valid", 32'(valid1), 32'd1);
        chk("odd_data", 32'(data1), 32'hA5);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("odd_ack", 32'(valid1), 32'd0);
        send(1, 8, 16'hA5, 1'b0, 1'b1);
        chk("odd_bad_error", 32'(error1), 32'd1);
        chk("odd_bad_data_kept", 32'(data1), 32'hA5);
        chk("odd_bad_valid", 32'(valid1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
